// File: rtl/rv32_pkg.sv
// Shared RV32I pipeline definitions: datapath width and the write-back
// result-select encodings used by the decode and write-back stages.
package rv32_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

endpackage : rv32_pkg

// File: rtl/wb_result_mux.sv
// Write-back result select: ALU result, load data or link address.
// Purely combinational; the reserved encoding yields zero.
module wb_result_mux
  import rv32_pkg::*;
#(
  parameter int W = XLEN
) (
  input  logic [1:0]   result_src,
  input  logic [W-1:0] alu_result,
  input  logic [W-1:0] mem_data,
  input  logic [W-1:0] pc_plus4,
  output logic [W-1:0] rd_data
);

  always_comb begin
    // NOTE: assign a default before the case so that no path leaves rd_data
    // unassigned, which would infer a latch.
    rd_data = '0;
    case (result_src)
      RES_ALU: rd_data = alu_result;
      RES_MEM: rd_data = mem_data;
      RES_PC4: rd_data = pc_plus4;
      default: rd_data = '0;
    endcase
  end

endmodule : wb_result_mux

// File: rtl/wb.sv
// RV32I write-back stage: result select, register-file write port,
// one-entry bypass copy of the last committed write, retired-instruction counter.
module wb
  import rv32_pkg::*;
#(
  parameter int XLEN_P = XLEN,
  parameter int CNT_W  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic              reg_write,
  input  logic [4:0]        rd_addr,
  input  logic [1:0]        result_src,
  input  logic [XLEN_P-1:0] alu_result,
  input  logic [XLEN_P-1:0] mem_data,
  input  logic [XLEN_P-1:0] pc_plus4,
  output logic [XLEN_P-1:0] rd_data,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [XLEN_P-1:0] rf_wdata,
  output logic              fwd_valid,
  output logic [4:0]        fwd_addr,
  output logic [XLEN_P-1:0] fwd_data,
  output logic [CNT_W-1:0]  instret
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic              fwd_valid_q, fwd_valid_d;
  logic [4:0]        fwd_addr_q,  fwd_addr_d;
  logic [XLEN_P-1:0] fwd_data_q,  fwd_data_d;
  logic [CNT_W-1:0]  instret_q,   instret_d;

  wb_result_mux #(
    .W (XLEN_P)
  ) u_result_mux (
    .result_src (result_src),
    .alu_result (alu_result),
    .mem_data   (mem_data),
    .pc_plus4   (pc_plus4),
    .rd_data    (rd_data)
  );

  // x0 is hardwired to zero, so writes to it never reach the register file.
  assign rf_we    = valid & reg_write & (rd_addr != 5'd0);
  assign rf_waddr = rd_addr;
  assign rf_wdata = rd_data;

  always_comb begin
    fwd_valid_d = rf_we;
    fwd_addr_d  = fwd_addr_q;
    fwd_data_d  = fwd_data_q;
    instret_d   = instret_q;
    if (rf_we) begin
      fwd_addr_d = rd_addr;
      fwd_data_d = rd_data;
    end
    if (valid) begin
      instret_d = instret_q + CNT_ONE;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples its next-state value from before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_valid_q <= 1'b0;
      fwd_addr_q  <= '0;
      fwd_data_q  <= '0;
      instret_q   <= '0;
    end else begin
      fwd_valid_q <= fwd_valid_d;
      fwd_addr_q  <= fwd_addr_d;
      fwd_data_q  <= fwd_data_d;
      instret_q   <= instret_d;
    end
  end

  assign fwd_valid = fwd_valid_q;
  assign fwd_addr  = fwd_addr_q;
  assign fwd_data  = fwd_data_q;
  assign instret   = instret_q;

endmodule : wb

// File: tb/tb_wb.sv
// Directed bench for the write-back stage: table-driven combinational
// vectors plus hand-written bypass, counter, reset and wrap sequences.
module tb_wb;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic        valid_s;
  logic        reg_write;
  logic [4:0]  rd_addr;
  logic [1:0]  result_src;
  logic [31:0] alu_result;
  logic [31:0] mem_data;
  logic [31:0] pc_plus4;

  logic [31:0] rd_data, rf_wdata, fwd_data;
  logic        rf_we, fwd_valid;
  logic [4:0]  rf_waddr, fwd_addr;
  logic [63:0] instret;

  logic [31:0] s_rd_data, s_rf_wdata, s_fwd_data;
  logic        s_rf_we, s_fwd_valid;
  logic [4:0]  s_rf_waddr, s_fwd_addr;
  logic [3:0]  s_instret;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  wb u_dut (
    .clk        (clk),
    .rst        (rst),
    .valid      (valid),
    .reg_write  (reg_write),
    .rd_addr    (rd_addr),
    .result_src (result_src),
    .alu_result (alu_result),
    .mem_data   (mem_data),
    .pc_plus4   (pc_plus4),
    .rd_data    (rd_data),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .fwd_valid  (fwd_valid),
    .fwd_addr   (fwd_addr),
    .fwd_data   (fwd_data),
    .instret    (instret)
  );

  // Narrow-counter instance for the wrap check.
  wb #(.CNT_W(4)) u_small (
    .clk        (clk),
    .rst        (rst),
    .valid      (valid_s),
    .reg_write  (reg_write),
    .rd_addr    (rd_addr),
    .result_src (result_src),
    .alu_result (alu_result),
    .mem_data   (mem_data),
    .pc_plus4   (pc_plus4),
    .rd_data    (s_rd_data),
    .rf_we      (s_rf_we),
    .rf_waddr   (s_rf_waddr),
    .rf_wdata   (s_rf_wdata),
    .fwd_valid  (s_fwd_valid),
    .fwd_addr   (s_fwd_addr),
    .fwd_data   (s_fwd_data),
    .instret    (s_instret)
  );

  typedef struct {
    logic        valid;
    logic        reg_write;
    logic [4:0]  rd_addr;
    logic [1:0]  src;
    logic [31:0] exp_data;
    logic        exp_we;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    valid      = 1'b0;
    valid_s    = 1'b0;
    reg_write  = 1'b0;
    rd_addr    = 5'd0;
    result_src = 2'b00;
    alu_result = 32'hAAAA_BBBB;
    mem_data   = 32'h1234_5678;
    pc_plus4   = 32'h0000_0100;

    vecs[0] = '{1'b0, 1'b0, 5'd0,  2'b00, 32'hAAAA_BBBB, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 5'd0,  2'b01, 32'h1234_5678, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 5'd0,  2'b10, 32'h0000_0100, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 5'd0,  2'b11, 32'h0000_0000, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 5'd9,  2'b01, 32'h1234_5678, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 5'd0,  2'b00, 32'hAAAA_BBBB, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 5'd31, 2'b10, 32'h0000_0100, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 5'd17, 2'b00, 32'hAAAA_BBBB, 1'b0};

    step();
    step();
    check("rst_fwd_valid", {63'd0, fwd_valid}, 64'd0);
    check("rst_fwd_addr",  {59'd0, fwd_addr},  64'd0);
    check("rst_fwd_data",  {32'd0, fwd_data},  64'd0);
    check("rst_instret",   instret,            64'd0);

    // Combinational vectors applied while still in reset.
    for (int i = 0; i < 8; i++) begin
      valid      = vecs[i].valid;
      reg_write  = vecs[i].reg_write;
      rd_addr    = vecs[i].rd_addr;
      result_src = vecs[i].src;
      #1;
      check($sformatf("vec%0d_rd_data", i),  {32'd0, rd_data},  {32'd0, vecs[i].exp_data});
      check($sformatf("vec%0d_rf_wdata", i), {32'd0, rf_wdata}, {32'd0, vecs[i].exp_data});
      check($sformatf("vec%0d_rf_we", i),    {63'd0, rf_we},    {63'd0, vecs[i].exp_we});
      check($sformatf("vec%0d_rf_waddr", i), {59'd0, rf_waddr}, {59'd0, vecs[i].rd_addr});
    end
    step();
    check("rst_hold_instret",   instret,            64'd0);
    check("rst_hold_fwd_valid", {63'd0, fwd_valid}, 64'd0);

    // Committed write to x5.
    rst        = 1'b0;
    valid      = 1'b1;
    reg_write  = 1'b1;
    rd_addr    = 5'd5;
    result_src = 2'b00;
    alu_result = 32'hDEAD_BEEF;
    #1;
    check("w5_rf_we", {63'd0, rf_we}, 64'd1);
    step();
    check("w5_fwd_valid", {63'd0, fwd_valid}, 64'd1);
    check("w5_fwd_addr",  {59'd0, fwd_addr},  64'd5);
    check("w5_fwd_data",  {32'd0, fwd_data},  64'hDEAD_BEEF);
    check("w5_instret",   instret,            64'd1);

    // Write to x0 is suppressed; bypass entry holds.
    rd_addr    = 5'd0;
    alu_result = 32'hCAFE_F00D;
    #1;
    check("x0_rf_we", {63'd0, rf_we}, 64'd0);
    step();
    check("x0_fwd_valid", {63'd0, fwd_valid}, 64'd0);
    check("x0_fwd_addr",  {59'd0, fwd_addr},  64'd5);
    check("x0_fwd_data",  {32'd0, fwd_data},  64'hDEAD_BEEF);
    check("x0_instret",   instret,            64'd2);

    // Reset wins over a simultaneous valid write.
    rst     = 1'b1;
    rd_addr = 5'd7;
    step();
    check("rprio_instret",   instret,            64'd0);
    check("rprio_fwd_valid", {63'd0, fwd_valid}, 64'd0);
    check("rprio_fwd_addr",  {59'd0, fwd_addr},  64'd0);
    check("rprio_fwd_data",  {32'd0, fwd_data},  64'd0);

    // Three retiring edges (one without a register write), then two bubbles.
    rst        = 1'b0;
    rd_addr    = 5'd3;
    alu_result = 32'h0000_0011;
    step();
    reg_write  = 1'b0;
    step();
    reg_write  = 1'b1;
    rd_addr    = 5'd4;
    result_src = 2'b01;
    mem_data   = 32'h0000_0022;
    step();
    check("seq_fwd_data_mem", {32'd0, fwd_data}, 64'h0000_0022);
    valid = 1'b0;
    step();
    step();
    check("seq_instret",   instret,            64'd3);
    check("seq_fwd_valid", {63'd0, fwd_valid}, 64'd0);
    check("seq_fwd_addr",  {59'd0, fwd_addr},  64'd4);
    check("seq_fwd_data",  {32'd0, fwd_data},  64'h0000_0022);

    // Counter wrap on the 4-bit instance.
    valid_s = 1'b1;
    for (int i = 0; i < 15; i++) step();
    check("wrap_full", {60'd0, s_instret}, 64'd15);
    step();
    check("wrap_zero", {60'd0, s_instret}, 64'd0);
    step();
    valid_s = 1'b0;
    check("wrap_one", {60'd0, s_instret}, 64'd1);
    check("wrap_main_idle", instret, 64'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_wb
